// File: rtl/inst_align_queue_if.sv
// Fetch-side and decode-side handshakes of the instruction align queue.
// master is the queue, slave is the fetch memory / ID stage environment.
interface inst_align_queue_if #(
  parameter int FETCH_HW = 2,
  parameter int PC_W     = 25
);
  logic                    flush_i;
  logic [PC_W-1:0]         flush_pc_i;
  logic                    fetch_req_o;
  logic [PC_W-1:0]         fetch_addr_o;
  logic                    fetch_gnt_i;
  logic                    fetch_valid_i;
  logic [16*FETCH_HW-1:0]  fetch_data_i;
  logic                    id_valid_o;
  logic                    id_ready_i;
  logic [63:0]             instruction_ID_o;
  logic [PC_W-1:0]         PC_ID_o;
  logic [1:0]              inst_len_o;

  modport master (
    input  flush_i, flush_pc_i, fetch_gnt_i, fetch_valid_i, fetch_data_i, id_ready_i,
    output fetch_req_o, fetch_addr_o, id_valid_o, instruction_ID_o, PC_ID_o, inst_len_o
  );

  modport slave (
    output flush_i, flush_pc_i, fetch_gnt_i, fetch_valid_i, fetch_data_i, id_ready_i,
    input  fetch_req_o, fetch_addr_o, id_valid_o, instruction_ID_o, PC_ID_o, inst_len_o
  );
endinterface

// File: rtl/inst_align_queue.sv
// Halfword prefetch queue that splits the fetched stream into V850 instructions
// (1, 2 or 3 halfwords) and hands them to decode one per handshake, with redirect.
module inst_align_queue #(
  parameter int              FETCH_HW = 2,
  parameter int              DEPTH_HW = 8,
  parameter int              PC_W     = 25,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  inst_align_queue_if.master  bus
);
  localparam int PTR_W  = $clog2(DEPTH_HW);
  localparam int CNT_W  = $clog2(DEPTH_HW + 1);
  localparam int SKIP_W = (FETCH_HW > 1) ? $clog2(FETCH_HW) : 1;
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(FETCH_HW - 1));

  function automatic logic [1:0] len_of(input logic [15:0] h);
    if (h[10:5] == 6'b110001 && h[15:11] == 5'd0) return 2'd3;
    else if (h[10:9] == 2'b11)                     return 2'd2;
    else                                           return 2'd1;
  endfunction

  // Queue depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [2:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(DEPTH_HW)) s = s - (PTR_W+1)'(DEPTH_HW);
    return s[PTR_W-1:0];
  endfunction

  function automatic logic [PC_W-1:0] align_down(input logic [PC_W-1:0] a);
    return a & ALIGN_MASK;
  endfunction

  function automatic logic [SKIP_W-1:0] skip_of(input logic [PC_W-1:0] a);
    return SKIP_W'(a & ~ALIGN_MASK);
  endfunction

  logic [15:0]       q [DEPTH_HW];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count, free;
  logic              outstanding, drop;
  logic [SKIP_W-1:0] skip;
  logic [PC_W-1:0]   pc, fetch_addr;

  logic [15:0] h0, h1, h2;
  logic [1:0]  len_raw;
  logic        id_valid, req, accept, resp, push, pop;
  logic [2:0]  push_n, pop_n;
  logic [63:0] inst;

  always_comb begin
    h0       = q[head];
    h1       = q[ptr_add(head, 3'd1)];
    h2       = q[ptr_add(head, 3'd2)];
    len_raw  = len_of(h0);
    id_valid = (count != '0) && (count >= CNT_W'(len_raw));
    free     = CNT_W'(DEPTH_HW) - count;
    req      = !outstanding && (free >= CNT_W'(FETCH_HW));
    accept   = req && bus.fetch_gnt_i;
    resp     = bus.fetch_valid_i && outstanding;
    push     = resp && !drop && !bus.flush_i;
    pop      = id_valid && bus.id_ready_i && !bus.flush_i;
    push_n   = 3'(FETCH_HW) - 3'(skip);
    pop_n    = pop ? {1'b0, len_raw} : 3'd0;
    inst     = '0;
    if (id_valid) begin
      inst[15:0] = h0;
      if (len_raw != 2'd1) inst[31:16] = h1;
      if (len_raw == 2'd3) inst[47:32] = h2;
    end
  end

  assign bus.fetch_req_o      = req;
  assign bus.fetch_addr_o     = fetch_addr;
  assign bus.id_valid_o       = id_valid;
  assign bus.instruction_ID_o = inst;
  assign bus.PC_ID_o          = pc;
  assign bus.inst_len_o       = (count != '0) ? len_raw : 2'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
      skip        <= skip_of(RESET_PC);
      pc          <= RESET_PC;
      fetch_addr  <= align_down(RESET_PC);
    end else begin
      outstanding <= (outstanding && !resp) || accept;
      if (bus.flush_i) begin
        // Anything still in flight (including a grant taken this cycle) is stale.
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        drop       <= (outstanding && !resp) || accept;
        skip       <= skip_of(bus.flush_pc_i);
        pc         <= bus.flush_pc_i;
        fetch_addr <= align_down(bus.flush_pc_i);
      end else begin
        if (resp) drop <= 1'b0;
        if (push) begin
          tail <= ptr_add(tail, push_n);
          skip <= '0;
        end
        if (pop) begin
          head <= ptr_add(head, pop_n);
          pc   <= pc + PC_W'(len_raw);
        end
        count <= count + CNT_W'(push_n & {3{push}}) - CNT_W'(pop_n);
        if (accept) fetch_addr <= fetch_addr + PC_W'(FETCH_HW);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      for (int k = 0; k < FETCH_HW; k++) begin
        if (k >= int'(skip)) q[ptr_add(tail, 3'(k) - 3'(skip))] <= bus.fetch_data_i[16*k +: 16];
      end
    end
  end
endmodule

// File: tb/tb_inst_align_queue.sv
// Directed bench for inst_align_queue: halfword memory responder plus hand-derived
// instruction/PC sequences for streaming, straddling, backpressure, flush and reset.
module tb_inst_align_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  inst_align_queue_if #(.FETCH_HW(2), .PC_W(25)) bus ();

  inst_align_queue #(.FETCH_HW(2), .DEPTH_HW(8), .PC_W(25), .RESET_PC('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [64];
  int          lat = 1;
  bit          gnt_en = 1'b0;
  bit          pend = 1'b0;
  logic [24:0] pend_addr = '0;
  int          wait_cnt = 0;
  int          beats = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Fetch memory: one beat in flight, response lat cycles after the grant edge.
  initial begin
    bus.fetch_valid_i = 1'b0;
    bus.fetch_gnt_i   = 1'b0;
    bus.fetch_data_i  = '0;
    forever begin
      @(negedge clk);
      bus.fetch_valid_i = 1'b0;
      if (pend) begin
        if (wait_cnt == 0) begin
          bus.fetch_valid_i = 1'b1;
          bus.fetch_data_i  = {mem[pend_addr[5:0] + 6'd1], mem[pend_addr[5:0]]};
          pend = 1'b0;
          beats++;
        end else begin
          wait_cnt--;
        end
      end
      bus.fetch_gnt_i = gnt_en && !pend;
      if (bus.fetch_req_o && bus.fetch_gnt_i) begin
        pend      = 1'b1;
        pend_addr = bus.fetch_addr_o;
        wait_cnt  = lat - 1;
      end
    end
  end

  task automatic take(input string tag, input logic [63:0] e_inst, input logic [1:0] e_len,
                      input logic [24:0] e_pc);
    int n = 0;
    while (!bus.id_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".valid"}, 64'(bus.id_valid_o), 64'd1);
    if (bus.id_valid_o) begin
      check({tag, ".inst"}, bus.instruction_ID_o, e_inst);
      check({tag, ".len"}, 64'(bus.inst_len_o), 64'(e_len));
      check({tag, ".pc"}, 64'(bus.PC_ID_o), 64'(e_pc));
      bus.id_ready_i = 1'b1;
      @(negedge clk);
      bus.id_ready_i = 1'b0;
    end
  endtask

  task automatic do_flush(input logic [24:0] target);
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = target;
    @(negedge clk);
    bus.flush_i    = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".req"}, 64'(bus.fetch_req_o), 64'd1);
    check({tag, ".addr"}, 64'(bus.fetch_addr_o), 64'd0);
    check({tag, ".valid"}, 64'(bus.id_valid_o), 64'd0);
    check({tag, ".pc"}, 64'(bus.PC_ID_o), 64'd0);
    check({tag, ".len"}, 64'(bus.inst_len_o), 64'd0);
    check({tag, ".inst"}, bus.instruction_ID_o, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int n;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[0] = 16'h11C1; mem[1] = 16'h125F; mem[2] = 16'h2141;
    mem[3] = 16'h1EC1; mem[4] = 16'h000B; mem[5] = 16'h21E1;
    mem[16] = 16'h0620; mem[17] = 16'h5678; mem[18] = 16'h1234; mem[19] = 16'h0001;
    for (int i = 24; i <= 40; i++) mem[i] = 16'h0100 + 16'(i - 24);
    for (int i = 40; i < 48; i++) mem[i] = 16'h7777;
    bus.flush_i    = 1'b0;
    bus.flush_pc_i = '0;
    bus.id_ready_i = 1'b0;

    // 1: reset values after release
    repeat (5) @(negedge clk);
    reset = 1'b0;
    check_reset_state("rst");

    // 2: mixed 16/32-bit stream from address 0
    lat = 1;
    gnt_en = 1'b1;
    take("s0", 64'h11C1, 2'd1, 25'd0);
    take("s1", 64'h125F, 2'd1, 25'd1);
    take("s2", 64'h2141, 2'd1, 25'd2);
    take("s3", 64'h0000_000B_1EC1, 2'd2, 25'd3);
    take("s4", 64'h21E1, 2'd1, 25'd5);

    // 3: MOV imm32 straddling two fetch beats
    gnt_en = 1'b0;
    repeat (10) @(negedge clk);
    lat = 3;
    beats = 0;
    do_flush(25'd16);
    gnt_en = 1'b1;
    n = 0;
    while (!bus.id_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mov.beats", 64'(beats), 64'd2);
    take("mov", 64'h0000_1234_5678_0620, 2'd3, 25'd16);

    // 4: backpressure fills the queue, then drains in order
    gnt_en = 1'b0;
    repeat (10) @(negedge clk);
    lat = 1;
    do_flush(25'd24);
    gnt_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 9) check("bp.hold_mid", bus.instruction_ID_o, 64'h0100);
    end
    check("bp.req", 64'(bus.fetch_req_o), 64'd0);
    check("bp.addr", 64'(bus.fetch_addr_o), 64'd32);
    check("bp.valid", 64'(bus.id_valid_o), 64'd1);
    check("bp.hold_end", bus.instruction_ID_o, 64'h0100);
    check("bp.pc", 64'(bus.PC_ID_o), 64'd24);
    for (int i = 0; i < 9; i++)
      take($sformatf("drain%0d", i), 64'h0100 + 64'(i), 2'd1, 25'(24 + i));

    // 5: flush with a fetch in flight; stale beat must be dropped
    lat = 6;
    @(negedge clk);
    do_flush(25'd40);
    check("fl.valid_clr", 64'(bus.id_valid_o), 64'd0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      #1;
      if (pend && wait_cnt >= 2) found = 1'b1;
    end
    check("fl.in_flight", 64'(found), 64'd1);
    do_flush(25'd5);
    lat = 1;
    check("fl.valid", 64'(bus.id_valid_o), 64'd0);
    check("fl.addr", 64'(bus.fetch_addr_o), 64'd4);
    check("fl.req", 64'(bus.fetch_req_o), 64'd0);
    take("fl0", 64'h21E1, 2'd1, 25'd5);
    take("fl1", 64'h0000, 2'd1, 25'd6);

    // 6: reset in a cycle with both a push and a pop pending
    do_flush(25'd24);
    take("rd0", 64'h0100, 2'd1, 25'd24);
    take("rd1", 64'h0101, 2'd1, 25'd25);
    bus.id_ready_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      #1;
      if (bus.fetch_valid_i && bus.id_valid_o) found = 1'b1;
    end
    check("rd.push_pop", 64'(found), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("rd.rst");
    bus.id_ready_i = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
